cv32e40x_pma_cfg_reader: RTL
============================

# cv32e40x_pma_cfg_reader

Read-out engine for the static PMA and debug-module region configuration. After elaboration, software and debug paths can only observe that configuration through this block. On a request it walks the `PMA_CFG` array and the DM region bounds and streams them as 32-bit words over a valid/ready response channel. It sits beside the PMA/MPU and feeds the custom CSR read path and the debug module's system-bus read-back.

## Interface
Parameters:
- `PMA_NUM_REGIONS`, default 0: number of configured PMA regions, range 0..16.
- `PMA_CFG[PMA_NUM_REGIONS-1:0]`, default `'{default:PMA_R_DEFAULT}`: region table of type `pma_cfg_t`.
- `DM_REGION_START`, default `32'hF0000000`: debug-module region start byte address.
- `DM_REGION_END`, default `32'hF0003FFF`: debug-module region end byte address.

Ports:
- `clk_i`, input, 1: the single clock.
- `rst_ni`, input, 1: asynchronous, active-low reset.
- `req_valid_i`, input, 1: request valid.
- `req_ready_o`, output, 1: request accepted when high together with `req_valid_i`.
- `req_mode_i`, input, 1: 0 = single region, 1 = full dump.
- `req_index_i`, input, 4: region index; used only in single mode.
- `rsp_valid_o`, output, 1: response word valid.
- `rsp_ready_i`, input, 1: consumer accepts the word.
- `rsp_word_o`, output, 32: response data.
- `rsp_last_o`, output, 1: final word of the transaction.
- `rsp_err_o`, output, 1: request was invalid (index out of range).

## Operation
- States: IDLE, HEADER, REGION, DM_START, DM_END, ERROR.
- Region word counter `word_cnt` runs 0..2. Region counter `reg_cnt` is 4 bits.
- `req_ready_o` = (state == IDLE). It is combinational from the state register.
- Per-region word sequence:
  - w0 = `{word_addr_low, 2'b00}`
  - w1 = `{word_addr_high, 2'b11}` (inclusive last byte)
  - w2 = `{28'b0, integrity, cacheable, bufferable, main}`
- Full dump sequence:
  - HEADER word `{24'b0, 3'b0, 5'(PMA_NUM_REGIONS)}`.
  - Then 3 words for each region, index 0 upward.
  - Then DM_START (`DM_REGION_START`).
  - Then DM_END (`DM_REGION_END`), with `rsp_last_o` = 1.
  - With `PMA_NUM_REGIONS` = 0: HEADER, DM_START, DM_END only.
- Single-region mode:
  - `req_index_i` < `PMA_NUM_REGIONS`: the 3 region words; `rsp_last_o` is set on w2.
  - Otherwise, including every request when `PMA_NUM_REGIONS` = 0: ERROR. One word `32'h0` is emitted with `rsp_err_o` = 1 and `rsp_last_o` = 1.
- `rsp_err_o` is 0 on every non-ERROR word.
- Index is 4 bits wide, so index 15 with 16 regions is legal. There is no wrap-around.
- Any requests arriving while not in IDLE are stalled by `req_ready_o` = 0. They are never dropped or queued.

## Timing
- Reset values: state IDLE, `req_ready_o` = 1, `rsp_valid_o` = 0, `rsp_word_o` = 0, `rsp_last_o` = 0, `rsp_err_o` = 0, counters 0.
- Latency: the first response word is registered and valid on the cycle after request acceptance.
- The response registers load the next word on the same edge as a `rsp_valid_o && rsp_ready_i` handshake.
  - With `rsp_ready_i` held high, throughput is one word per cycle.
  - Full dump takes 3×N+3 cycles.
- While `rsp_valid_o` = 1 and `rsp_ready_i` = 0, `rsp_word_o`, `rsp_last_o` and `rsp_err_o` hold stable.
- On the handshake of the last word:
  - `rsp_valid_o` drops next cycle unless a new beat is loaded.
  - State returns to IDLE, so `req_ready_o` = 1 one cycle after the last handshake.
- Request inputs are not sampled outside IDLE.
- Reset asserted mid-transaction aborts immediately and asynchronously to reset values. No partial-completion signalling is produced.

## Structure
- Add to `cv32e40x_pkg`:
  - `pma_rd_state_e` enum.
  - `pma_rd_mode_e` (`PMA_RD_SINGLE` = 0, `PMA_RD_DUMP` = 1).
  - Attribute bit-position constants `PMA_RD_ATTR_MAIN` .. `PMA_RD_ATTR_INTEGRITY`.
  - Function `pma_cfg_word(pma_cfg_t cfg, logic [1:0] sel)` returning w0/w1/w2.
- No sub-module. One FSM plus the output register stage.
- Bind `cv32e40x_pma_cfg_reader_sva` for the following properties:
  - Handshake stability.
  - `rsp_last_o` once per transaction.
  - Word count per mode.

## Test plan
- `PMA_NUM_REGIONS` = 2, region0 low=`30'h0` high=`30'h3FFF` main=1, dump with ready=1 → words `0x2`, `0x0`, `0xFFFF`, `0x1`, …, `0xF0000000`, `0xF0003FFF` (last=1); 9 consecutive cycles.
- Single mode, index 1 → exactly 3 words, last only on the attribute word, err=0.
- Single mode, index 5 with 2 regions → one word `0x0`, err=1, last=1; req_ready back to 1 the next cycle.
- Dump with `rsp_ready_i` toggling 1,0,0,1 → each word held stable during stalls; no word lost or duplicated; order unchanged.
- `rst_ni` asserted after the 4th word of a dump → all outputs at reset values immediately. A subsequent dump starts from HEADER.
- `PMA_NUM_REGIONS` = 0 → dump gives 3 words (`0x0`, DM start, DM end); every single request gives err=1.

Source files
------------

// File: rtl/cv32e40x_pkg.sv
// Shared cv32e40x types: the static PMA region descriptor plus the types and
// helpers used by the PMA configuration read-out engine.
package cv32e40x_pkg;

    typedef struct packed {
        logic [29:0] word_addr_low;
        logic [29:0] word_addr_high;
        logic        main;
        logic        bufferable;
        logic        cacheable;
        logic        integrity;
    } pma_cfg_t;

    localparam pma_cfg_t PMA_R_DEFAULT = '{
        word_addr_low:  30'h0000_0000,
        word_addr_high: 30'h3FFF_FFFF,
        main:           1'b1,
        bufferable:     1'b0,
        cacheable:      1'b0,
        integrity:      1'b0
    };

    typedef enum logic [2:0] {
        PMA_RD_IDLE,
        PMA_RD_HEADER,
        PMA_RD_REGION,
        PMA_RD_DM_START,
        PMA_RD_DM_END,
        PMA_RD_ERROR
    } pma_rd_state_e;

    typedef enum logic {
        PMA_RD_SINGLE = 1'b0,
        PMA_RD_DUMP   = 1'b1
    } pma_rd_mode_e;

    localparam logic [4:0] PMA_RD_ATTR_MAIN       = 5'd0;
    localparam logic [4:0] PMA_RD_ATTR_BUFFERABLE = 5'd1;
    localparam logic [4:0] PMA_RD_ATTR_CACHEABLE  = 5'd2;
    localparam logic [4:0] PMA_RD_ATTR_INTEGRITY  = 5'd3;

    // Word addresses are widened back to byte addresses; the high bound is inclusive.
    function automatic logic [31:0] pma_cfg_word(pma_cfg_t cfg, logic [1:0] sel);
        logic [31:0] word;
        word = '0;
        case (sel)
            2'd0:    word = {cfg.word_addr_low, 2'b00};
            2'd1:    word = {cfg.word_addr_high, 2'b11};
            default: begin
                word[PMA_RD_ATTR_MAIN]       = cfg.main;
                word[PMA_RD_ATTR_BUFFERABLE] = cfg.bufferable;
                word[PMA_RD_ATTR_CACHEABLE]  = cfg.cacheable;
                word[PMA_RD_ATTR_INTEGRITY]  = cfg.integrity;
            end
        endcase
        return word;
    endfunction

endpackage

// File: rtl/cv32e40x_pma_cfg_reader_sva.sv
// Protocol checker for the PMA configuration reader, bound into every instance:
// stall stability, a single last beat per transaction and per-mode word counts.
module cv32e40x_pma_cfg_reader_sva #(
    parameter int PMA_NUM_REGIONS = 0
) (
    input logic        clk_i,
    input logic        rst_ni,
    input logic        req_valid_i,
    input logic        req_ready_o,
    input logic        req_mode_i,
    input logic [3:0]  req_index_i,
    input logic        rsp_valid_o,
    input logic        rsp_ready_i,
    input logic [31:0] rsp_word_o,
    input logic        rsp_last_o,
    input logic        rsp_err_o
);

    localparam logic [5:0] DUMP_WORDS = 6'(3 * PMA_NUM_REGIONS + 3);

    logic [5:0] beat_cnt;
    logic [5:0] exp_cnt;
    logic       rsp_hs;

    assign rsp_hs = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt <= '0;
            exp_cnt  <= '0;
        end else if (req_valid_i && req_ready_o) begin
            beat_cnt <= '0;
            if (req_mode_i) begin
                exp_cnt <= DUMP_WORDS;
            end else if ({1'b0, req_index_i} < 5'(PMA_NUM_REGIONS)) begin
                exp_cnt <= 6'd3;
            end else begin
                exp_cnt <= 6'd1;
            end
        end else if (rsp_hs) begin
            beat_cnt <= beat_cnt + 6'd1;
        end
    end

    a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rsp_valid_o && !rsp_ready_i) |=>
            (rsp_valid_o && $stable(rsp_word_o) && $stable(rsp_last_o) && $stable(rsp_err_o)));

    a_last_once: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rsp_hs && !rsp_last_o) |-> (beat_cnt + 6'd1 < exp_cnt));

    a_word_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rsp_hs && rsp_last_o) |-> (beat_cnt + 6'd1 == exp_cnt));

endmodule

bind cv32e40x_pma_cfg_reader cv32e40x_pma_cfg_reader_sva #(
    .PMA_NUM_REGIONS (PMA_NUM_REGIONS)
) u_pma_cfg_reader_sva (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_mode_i  (req_mode_i),
    .req_index_i (req_index_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_word_o  (rsp_word_o),
    .rsp_last_o  (rsp_last_o),
    .rsp_err_o   (rsp_err_o)
);

// File: rtl/cv32e40x_pma_cfg_reader.sv
// Streams the static PMA table and debug-module bounds as 32-bit words over a
// valid/ready channel, either one region or a full dump per request.
module cv32e40x_pma_cfg_reader
    import cv32e40x_pkg::*;
#(
    parameter int          PMA_NUM_REGIONS = 0,
    parameter pma_cfg_t    PMA_CFG[PMA_NUM_REGIONS-1:0] = '{default: PMA_R_DEFAULT},
    parameter logic [31:0] DM_REGION_START = 32'hF000_0000,
    parameter logic [31:0] DM_REGION_END   = 32'hF000_3FFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_mode_i,
    input  logic [3:0]  req_index_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_word_o,
    output logic        rsp_last_o,
    output logic        rsp_err_o
);

    localparam logic [4:0] NUM_REGIONS = 5'(PMA_NUM_REGIONS);

    pma_rd_state_e state_q, state_d;
    pma_rd_mode_e  mode_q, mode_d;
    logic [1:0]    word_cnt_q, word_cnt_d;
    logic [3:0]    reg_cnt_q, reg_cnt_d;
    logic          rsp_hs;
    pma_cfg_t      sel_cfg;
    logic          rsp_valid_d;
    logic [31:0]   rsp_word_d;
    logic          rsp_last_d;
    logic          rsp_err_d;

    assign req_ready_o = (state_q == PMA_RD_IDLE);
    assign rsp_hs      = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= PMA_RD_IDLE;
            mode_q     <= PMA_RD_SINGLE;
            word_cnt_q <= '0;
            reg_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            word_cnt_q <= word_cnt_d;
            reg_cnt_q  <= reg_cnt_d;
        end
    end

    // The state names the word held in the response register, so each
    // handshake advances to the word that is loaded on that same edge.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        word_cnt_d = word_cnt_q;
        reg_cnt_d  = reg_cnt_q;
        case (state_q)
            PMA_RD_IDLE: begin
                if (req_valid_i) begin
                    mode_d     = pma_rd_mode_e'(req_mode_i);
                    word_cnt_d = '0;
                    reg_cnt_d  = '0;
                    if (req_mode_i) begin
                        state_d = PMA_RD_HEADER;
                    end else if ({1'b0, req_index_i} < NUM_REGIONS) begin
                        state_d   = PMA_RD_REGION;
                        reg_cnt_d = req_index_i;
                    end else begin
                        state_d = PMA_RD_ERROR;
                    end
                end
            end
            PMA_RD_HEADER: begin
                if (rsp_hs) begin
                    state_d = (NUM_REGIONS == 5'd0) ? PMA_RD_DM_START : PMA_RD_REGION;
                end
            end
            PMA_RD_REGION: begin
                if (rsp_hs) begin
                    if (word_cnt_q != 2'd2) begin
                        word_cnt_d = word_cnt_q + 2'd1;
                    end else if (mode_q == PMA_RD_SINGLE) begin
                        state_d    = PMA_RD_IDLE;
                        word_cnt_d = '0;
                        reg_cnt_d  = '0;
                    end else if ({1'b0, reg_cnt_q} + 5'd1 == NUM_REGIONS) begin
                        state_d    = PMA_RD_DM_START;
                        word_cnt_d = '0;
                        reg_cnt_d  = '0;
                    end else begin
                        word_cnt_d = '0;
                        reg_cnt_d  = reg_cnt_q + 4'd1;
                    end
                end
            end
            PMA_RD_DM_START: if (rsp_hs) state_d = PMA_RD_DM_END;
            PMA_RD_DM_END:   if (rsp_hs) state_d = PMA_RD_IDLE;
            PMA_RD_ERROR:    if (rsp_hs) state_d = PMA_RD_IDLE;
            default:         state_d = PMA_RD_IDLE;
        endcase
    end

    always_comb begin
        sel_cfg = PMA_CFG[0];
        for (int i = 1; i < PMA_NUM_REGIONS; i++) begin
            if (reg_cnt_d == 4'(i)) sel_cfg = PMA_CFG[i];
        end
    end

    always_comb begin
        rsp_valid_d = (state_d != PMA_RD_IDLE);
        rsp_err_d   = (state_d == PMA_RD_ERROR);
        rsp_last_d  = (state_d == PMA_RD_DM_END) || (state_d == PMA_RD_ERROR) ||
                      ((state_d == PMA_RD_REGION) && (mode_d == PMA_RD_SINGLE) &&
                       (word_cnt_d == 2'd2));
        rsp_word_d  = '0;
        case (state_d)
            PMA_RD_HEADER:   rsp_word_d = {27'b0, NUM_REGIONS};
            PMA_RD_REGION:   rsp_word_d = pma_cfg_word(sel_cfg, word_cnt_d);
            PMA_RD_DM_START: rsp_word_d = DM_REGION_START;
            PMA_RD_DM_END:   rsp_word_d = DM_REGION_END;
            default:         rsp_word_d = '0;
        endcase
    end

    // Without a handshake the next-word values equal the current ones, so stalls hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_word_o  <= '0;
            rsp_last_o  <= 1'b0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= rsp_valid_d;
            rsp_word_o  <= rsp_word_d;
            rsp_last_o  <= rsp_last_d;
            rsp_err_o   <= rsp_err_d;
        end
    end

endmodule
